// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix definitions: HTRANS/HRESP encodings, address-phase field widths,
// and the input-stage state encoding.
package ahb_mtx_pkg;

    localparam int ADDR_W  = 32;
    localparam int TRANS_W = 2;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 3;
    localparam int PROT_W  = 4;

    typedef enum logic [TRANS_W-1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic [TRANS_W-1:0] trans;
        logic [ADDR_W-1:0]  addr;
        logic               write;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [PROT_W-1:0]  prot;
    } addr_phase_t;

    // Encoded directly as {pend_tran, data_valid}
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DATA      = 2'b01,
        ST_PEND      = 2'b10,
        ST_PEND_DATA = 2'b11
    } stg_state_e;

endpackage

// File: rtl/ahb_mtx_in_stg_hold.sv
// Address-phase holding register for the matrix input stage.
// HMASTLOCK storage exists only when AHB_MTX_IN_STG_LOCK_EN is defined.
module ahb_mtx_in_stg_hold
    import ahb_mtx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cap,
    input  logic        clr,
    input  addr_phase_t fields_in,
`ifdef AHB_MTX_IN_STG_LOCK_EN
    input  logic        lock_in,
    output logic        lock_out,
`endif
    output addr_phase_t fields_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fields_out <= '0;
        else if (clr)
            fields_out <= '0;
        else if (cap)
            fields_out <= fields_in;
    end

`ifdef AHB_MTX_IN_STG_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock_out <= 1'b0;
        else if (clr)
            lock_out <= 1'b0;
        else if (cap)
            lock_out <= lock_in;
    end
`endif

endmodule

// File: rtl/ahb_mtx_in_stg.sv
// AHB matrix input stage: passes the address phase straight through, or holds it
// while the output arbiter is busy. Lock forwarding enabled by AHB_MTX_IN_STG_LOCK_EN.
module ahb_mtx_in_stg
    import ahb_mtx_pkg::*;
(
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELS,
    input  logic [TRANS_W-1:0] HTRANSS,
    input  logic [ADDR_W-1:0]  HADDRS,
    input  logic               HWRITES,
    input  logic [SIZE_W-1:0]  HSIZES,
    input  logic [BURST_W-1:0] HBURSTS,
    input  logic [PROT_W-1:0]  HPROTS,
    input  logic               HMASTLOCKS,
    input  logic               HREADYS,
    output logic               HREADYOUTS,
    output logic               HRESPS,
    output logic               req_port,
    output logic [TRANS_W-1:0] sel_trans,
    output logic [ADDR_W-1:0]  sel_addr,
    output logic               sel_write,
    output logic [SIZE_W-1:0]  sel_size,
    output logic [BURST_W-1:0] sel_burst,
    output logic [PROT_W-1:0]  sel_prot,
    output logic               sel_lock,
    input  logic               addr_accept,
    input  logic               data_ready_in,
    input  logic               data_resp_in
);

    stg_state_e  state, state_nxt;
    logic        pend_tran, data_valid;
    logic        live, capture, nxt_pend, nxt_dv;
    addr_phase_t live_ph, held_ph;

    assign pend_tran = state[1];
    assign data_valid = state[0];

    // BUSY carries no beat for the slave, so only NONSEQ/SEQ (HTRANS[1]) request the port
    assign live    = HSELS & HREADYS & HTRANSS[1];
    assign capture = live & ~addr_accept & ~pend_tran;

    assign live_ph.trans = HTRANSS;
    assign live_ph.addr  = HADDRS;
    assign live_ph.write = HWRITES;
    assign live_ph.size  = HSIZES;
    assign live_ph.burst = HBURSTS;
    assign live_ph.prot  = HPROTS;

    ahb_mtx_in_stg_hold u_hold (
        .clk       (HCLK),
        .rst       (HRESET),
        .cap       (capture),
        .clr       (pend_tran & addr_accept),
        .fields_in (live_ph),
`ifdef AHB_MTX_IN_STG_LOCK_EN
        .lock_in   (HMASTLOCKS),
        .lock_out  (sel_lock),
`endif
        .fields_out(held_ph)
    );

`ifndef AHB_MTX_IN_STG_LOCK_EN
    logic lock_unused;
    assign lock_unused = HMASTLOCKS;
    assign sel_lock    = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        nxt_pend  = pend_tran ? ~addr_accept : capture;
        nxt_dv    = addr_accept | (data_valid & ~data_ready_in);
        state_nxt = stg_state_e'({nxt_pend, nxt_dv});
    end

    always_comb begin
        HREADYOUTS = ~pend_tran & (~data_valid | data_ready_in);
        HRESPS     = (data_valid & data_resp_in) ? HRESP_ERROR : HRESP_OKAY;
        req_port   = ~HRESET & (pend_tran | live);
        sel_addr   = pend_tran ? held_ph.addr  : HADDRS;
        sel_write  = pend_tran ? held_ph.write : HWRITES;
        sel_size   = pend_tran ? held_ph.size  : HSIZES;
        sel_burst  = pend_tran ? held_ph.burst : HBURSTS;
        sel_prot   = pend_tran ? held_ph.prot  : HPROTS;
        sel_trans  = HTRANSS;
        // The output slave never saw the preceding beat, so a held SEQ restarts as NONSEQ
        if (HRESET)
            sel_trans = HTRANS_IDLE;
        else if (pend_tran)
            sel_trans = (held_ph.trans == HTRANS_SEQ || held_ph.trans == HTRANS_BUSY)
                        ? HTRANS_NONSEQ : held_ph.trans;
    end

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Self-checking bench for ahb_mtx_in_stg; accepted addresses are tracked by a scoreboard
// queue. Honours AHB_MTX_IN_STG_LOCK_EN for the lock expectation.
module tb_ahb_mtx_in_stg;
    import ahb_mtx_pkg::*;

`ifdef AHB_MTX_IN_STG_LOCK_EN
    localparam logic LOCK_EXP = 1'b1;
`else
    localparam logic LOCK_EXP = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [1:0]  HTRANSS;
    logic [31:0] HADDRS;
    logic [2:0]  HSIZES, HBURSTS;
    logic [3:0]  HPROTS;
    logic        addr_accept, data_ready_in, data_resp_in;
    logic        HREADYOUTS, HRESPS, req_port, sel_write, sel_lock;
    logic [1:0]  sel_trans;
    logic [31:0] sel_addr;
    logic [2:0]  sel_size, sel_burst;
    logic [3:0]  sel_prot;

    int          n_pass = 0;
    int          n_tot = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stg u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HTRANSS(HTRANSS), .HADDRS(HADDRS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .req_port(req_port), .sel_trans(sel_trans), .sel_addr(sel_addr), .sel_write(sel_write),
        .sel_size(sel_size), .sel_burst(sel_burst), .sel_prot(sel_prot), .sel_lock(sel_lock),
        .addr_accept(addr_accept), .data_ready_in(data_ready_in), .data_resp_in(data_resp_in)
    );

    // Every accepted address phase must match the next expected address in order
    always @(negedge HCLK) begin
        if (!HRESET && req_port && addr_accept) begin
            n_tot++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got accept of %h, required none", sel_addr);
            end else begin
                sb_exp = sb_q.pop_front();
                if (sel_addr !== sb_exp)
                    $display("FAIL sb_addr: got %h, required %h", sel_addr, sb_exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic idle_in();
        HSELS = 0; HTRANSS = HTRANS_IDLE; HADDRS = '0; HWRITES = 0; HSIZES = 3'd2;
        HBURSTS = 3'd0; HPROTS = 4'd3; HMASTLOCKS = 0; HREADYS = 1;
        addr_accept = 0; data_ready_in = 1; data_resp_in = 0;
    endtask

    task automatic nonseq(input logic [31:0] a, input logic acc);
        HSELS = 1; HTRANSS = HTRANS_NONSEQ; HADDRS = a; HREADYS = 1; addr_accept = acc;
    endtask

    task automatic test_reset();
        idle_in();
        HRESET = 1;
        nonseq(32'h5000_0000, 1'b0);
        smp();
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL rst_rdy: got %b, required 1", HREADYOUTS); else n_pass++;
        n_tot++; if (HRESPS !== 1'b0) $display("FAIL rst_resp: got %b, required 0", HRESPS); else n_pass++;
        n_tot++; if (req_port !== 1'b0) $display("FAIL rst_req: got %b, required 0", req_port); else n_pass++;
        n_tot++; if (sel_trans !== 2'b00) $display("FAIL rst_trans: got %b, required 00", sel_trans); else n_pass++;
        cyc(); HRESET = 0; idle_in();
        cyc();
    endtask

    task automatic test_accept_same_cycle();
        nonseq(32'h2000_0000, 1'b1); HWRITES = 1;
        sb_q.push_back(32'h2000_0000);
        smp();
        n_tot++; if (sel_addr !== 32'h2000_0000) $display("FAIL pass_addr: got %h, required 20000000", sel_addr); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL pass_rdy: got %b, required 1", HREADYOUTS); else n_pass++;
        n_tot++; if (sel_write !== 1'b1) $display("FAIL pass_write: got %b, required 1", sel_write); else n_pass++;
        cyc(); idle_in();
        smp();
        n_tot++; if (req_port !== 1'b0) $display("FAIL pass_nopend: got %b, required 0", req_port); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL pass_data_rdy: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc();
    endtask

    task automatic test_hold_and_seq();
        nonseq(32'h1000_0040, 1'b0);
        sb_q.push_back(32'h1000_0040);
        smp();
        n_tot++; if (req_port !== 1'b1) $display("FAIL hold_req0: got %b, required 1", req_port); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            HREADYS = 0; HADDRS = 32'h1000_0040 + 32'(4 * i); addr_accept = (i == 3);
            smp();
            n_tot++; if (HREADYOUTS !== 1'b0) $display("FAIL hold_rdy c%0d: got %b, required 0", i, HREADYOUTS); else n_pass++;
            n_tot++; if (sel_addr !== 32'h1000_0040) $display("FAIL hold_addr c%0d: got %h, required 10000040", i, sel_addr); else n_pass++;
            n_tot++; if (req_port !== 1'b1) $display("FAIL hold_req c%0d: got %b, required 1", i, req_port); else n_pass++;
        end
        // Next beat is SEQ and gets held too
        cyc();
        HREADYS = 1; HTRANSS = HTRANS_SEQ; HADDRS = 32'h1000_0044; addr_accept = 0;
        sb_q.push_back(32'h1000_0044);
        smp();
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL seq_rdy_in: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc();
        HREADYS = 0; HADDRS = 32'h1000_0048; addr_accept = 1;
        smp();
        n_tot++; if (sel_trans !== 2'b10) $display("FAIL seq_as_nonseq: got %b, required 10", sel_trans); else n_pass++;
        n_tot++; if (sel_addr !== 32'h1000_0044) $display("FAIL seq_addr: got %h, required 10000044", sel_addr); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b0) $display("FAIL seq_stall: got %b, required 0", HREADYOUTS); else n_pass++;
        cyc(); idle_in();
        smp();
        n_tot++; if (req_port !== 1'b0) $display("FAIL seq_pend_clr: got %b, required 0", req_port); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL seq_rdy_after: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc();
    endtask

    task automatic test_data_wait();
        nonseq(32'h3000_0000, 1'b1);
        sb_q.push_back(32'h3000_0000);
        smp();
        for (int i = 1; i <= 2; i++) begin
            cyc(); idle_in(); data_ready_in = 0;
            smp();
            n_tot++; if (HREADYOUTS !== 1'b0) $display("FAIL dwait_rdy c%0d: got %b, required 0", i, HREADYOUTS); else n_pass++;
        end
        cyc(); data_ready_in = 1; data_resp_in = 1;
        smp();
        n_tot++; if (HRESPS !== 1'b1) $display("FAIL dwait_err: got %b, required 1", HRESPS); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL dwait_done: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc();
        smp();
        n_tot++; if (HRESPS !== 1'b0) $display("FAIL dwait_resp_clr: got %b, required 0", HRESPS); else n_pass++;
        cyc(); idle_in();
    endtask

    task automatic test_back_to_back();
        nonseq(32'h6000_0000, 1'b1);
        sb_q.push_back(32'h6000_0000);
        cyc();
        nonseq(32'h6000_0004, 1'b1); data_ready_in = 1;
        sb_q.push_back(32'h6000_0004);
        smp();
        cyc(); idle_in(); data_ready_in = 0;
        smp();
        n_tot++; if (HREADYOUTS !== 1'b0) $display("FAIL b2b_dv_kept: got %b, required 0", HREADYOUTS); else n_pass++;
        cyc(); data_ready_in = 1;
        smp();
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL b2b_done: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc(); idle_in();
    endtask

    task automatic test_busy_idle();
        logic [1:0] tr;
        for (int i = 0; i < 2; i++) begin
            tr = (i == 0) ? HTRANS_BUSY : HTRANS_IDLE;
            HSELS = 1; HTRANSS = tr; HADDRS = 32'h7000_0000; HREADYS = 1;
            smp();
            n_tot++; if (req_port !== 1'b0) $display("FAIL noxfer_req t%0d: got %b, required 0", tr, req_port); else n_pass++;
            n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL noxfer_rdy t%0d: got %b, required 1", tr, HREADYOUTS); else n_pass++;
            n_tot++; if (HRESPS !== 1'b0) $display("FAIL noxfer_resp t%0d: got %b, required 0", tr, HRESPS); else n_pass++;
            cyc();
        end
        idle_in();
        smp();
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL noxfer_after: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        nonseq(32'h4000_0000, 1'b1);
        sb_q.push_back(32'h4000_0000);
        cyc();
        nonseq(32'h4000_0004, 1'b0); data_ready_in = 0;
        cyc();
        HREADYS = 0;
        smp();
        n_tot++; if (HREADYOUTS !== 1'b0) $display("FAIL pd_rdy: got %b, required 0", HREADYOUTS); else n_pass++;
        n_tot++; if (req_port !== 1'b1) $display("FAIL pd_req: got %b, required 1", req_port); else n_pass++;
        HRESET = 1;
        cyc();
        HREADYS = 1;
        smp();
        n_tot++; if (req_port !== 1'b0) $display("FAIL rstmid_req: got %b, required 0", req_port); else n_pass++;
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL rstmid_rdy: got %b, required 1", HREADYOUTS); else n_pass++;
        n_tot++; if (sel_trans !== 2'b00) $display("FAIL rstmid_trans: got %b, required 00", sel_trans); else n_pass++;
        cyc(); HRESET = 0; idle_in(); data_ready_in = 0;
        smp();
        n_tot++; if (HREADYOUTS !== 1'b1) $display("FAIL rstmid_after: got %b, required 1", HREADYOUTS); else n_pass++;
        cyc(); idle_in();
    endtask

    task automatic test_lock();
        nonseq(32'h8000_0000, 1'b0); HMASTLOCKS = 1;
        sb_q.push_back(32'h8000_0000);
        cyc();
        HMASTLOCKS = 0; HREADYS = 0; addr_accept = 1;
        smp();
        n_tot++; if (sel_lock !== LOCK_EXP) $display("FAIL lock_held: got %b, required %b", sel_lock, LOCK_EXP); else n_pass++;
        n_tot++; if (sel_addr !== 32'h8000_0000) $display("FAIL lock_addr: got %h, required 80000000", sel_addr); else n_pass++;
        cyc(); idle_in();
        cyc();
    endtask

    initial begin
        test_reset();
        test_accept_same_cycle();
        test_hold_and_seq();
        test_data_wait();
        test_back_to_back();
        test_busy_idle();
        test_reset_mid();
        test_lock();
        smp();
        n_tot++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
